// File: rtl/scan_doubler.sv
// scan_doubler: captures each input scanline into a ping-pong buffer and replays it twice at double pixel rate with regenerated sync.
module scan_doubler #(
  parameter int H_TOTAL      = 341,
  parameter int H_ACTIVE     = 256,
  parameter int HS_START     = 275,
  parameter int HS_END       = 300,
  parameter int SCANLINE_DIM = 0
) (
  input  logic       I_clock,
  input  logic       I_reset,
  input  logic       I_vid_rise,
  input  logic       I_vid_blank,
  input  logic       I_vid_hsync,
  input  logic       I_vid_vsync,
  input  logic [7:0] I_vid_red,
  input  logic [7:0] I_vid_green,
  input  logic [7:0] I_vid_blue,
  output logic       O_out_rise,
  output logic       O_out_active,
  output logic       O_out_hsync,
  output logic       O_out_vsync,
  output logic       O_out_pass,
  output logic [7:0] O_out_red,
  output logic [7:0] O_out_green,
  output logic [7:0] O_out_blue
);
  localparam int AW = $clog2(H_ACTIVE);
  localparam int CW = $clog2((H_TOTAL > H_ACTIVE ? H_TOTAL : H_ACTIVE) + 1);
  localparam logic [CW-1:0] HA   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] HSS  = CW'(HS_START);
  localparam logic [CW-1:0] HSE  = CW'(HS_END);

  logic [23:0]   mem [2*H_ACTIVE];
  logic [23:0]   rd_data, pix, pix_o;
  logic [CW-1:0] in_x, in_nxt, line_len, out_x;
  logic          hs_prev, line_edge, wr, wr_bank, vs_line, phase, pass;
  logic          s1_phase, s1_pass, s1_active, s1_hs, s1_vs;

  always_comb begin
    line_edge = hs_prev & ~I_vid_hsync;
    wr        = I_vid_rise & I_vid_blank & (in_x < HA);
    in_nxt    = in_x + CW'(wr);
    pix       = s1_active ? rd_data : '0;
    pix_o     = (SCANLINE_DIM != 0 && s1_pass) ?
                {1'b0, pix[23:17], 1'b0, pix[15:9], 1'b0, pix[7:1]} : pix;
  end

  // Capture and replay always target opposite banks, so no read/write hazard.
  always_ff @(posedge I_clock) begin
    if (wr) mem[{wr_bank, in_x[AW-1:0]}] <= {I_vid_red, I_vid_green, I_vid_blue};
    rd_data <= mem[{~wr_bank, out_x[AW-1:0]}];
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      hs_prev      <= 1'b1;
      wr_bank      <= 1'b0;
      in_x         <= '0;
      line_len     <= '0;
      vs_line      <= 1'b1;
      out_x        <= '0;
      phase        <= 1'b0;
      pass         <= 1'b0;
      s1_phase     <= 1'b1;
      s1_pass      <= 1'b0;
      s1_active    <= 1'b0;
      s1_hs        <= 1'b1;
      s1_vs        <= 1'b1;
      O_out_rise   <= 1'b0;
      O_out_active <= 1'b0;
      O_out_hsync  <= 1'b1;
      O_out_vsync  <= 1'b1;
      O_out_pass   <= 1'b0;
      {O_out_red, O_out_green, O_out_blue} <= '0;
    end else begin
      hs_prev <= I_vid_hsync;
      if (line_edge) begin
        wr_bank  <= ~wr_bank;
        line_len <= in_nxt;
        in_x     <= '0;
        vs_line  <= I_vid_vsync;
        out_x    <= '0;
        pass     <= 1'b0;
        phase    <= 1'b0;
      end else begin
        in_x  <= in_nxt;
        phase <= ~phase;
        if (phase) begin
          out_x <= (out_x == LAST) ? '0 : out_x + 1'b1;
          if (out_x == LAST) pass <= ~pass;
        end
      end
      s1_phase     <= phase;
      s1_pass      <= pass;
      s1_active    <= (out_x < line_len) && (out_x < HA);
      s1_hs        <= ~((out_x >= HSS) && (out_x <= HSE));
      s1_vs        <= vs_line;
      O_out_rise   <= ~s1_phase;
      O_out_active <= s1_active;
      O_out_hsync  <= s1_hs;
      O_out_vsync  <= s1_vs;
      O_out_pass   <= s1_pass;
      {O_out_red, O_out_green, O_out_blue} <= pix_o;
    end
  end
endmodule

// File: tb/tb_scan_doubler.sv
// tb_scan_doubler: drives synthetic video lines into two scan_doubler instances (dim off/on)
// and compares every output cycle against a time-since-edge reference model.
module tb_scan_doubler;
  localparam int HT = 341;
  localparam logic [28:0] RST = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};

  typedef struct {
    int npix;
    int kind;
    bit vs;
    int total;
    int exp;
  } vec_t;

  logic clk = 0, rst = 0, rise = 0, blank = 0, hs = 1, vs = 1;
  logic [7:0] r = 0, g = 0, b = 0;
  logic rise0, act0, hs0, vs0, pass0, rise1, act1, hs1, vs1, pass1;
  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic [28:0] got0, got1;
  assign got0 = {rise0, act0, hs0, vs0, pass0, r0, g0, b0};
  assign got1 = {rise1, act1, hs1, vs1, pass1, r1, g1, b1};

  always #5 clk = ~clk;

  scan_doubler #(.SCANLINE_DIM(0)) u0 (
    .I_clock(clk), .I_reset(rst), .I_vid_rise(rise), .I_vid_blank(blank),
    .I_vid_hsync(hs), .I_vid_vsync(vs), .I_vid_red(r), .I_vid_green(g), .I_vid_blue(b),
    .O_out_rise(rise0), .O_out_active(act0), .O_out_hsync(hs0), .O_out_vsync(vs0),
    .O_out_pass(pass0), .O_out_red(r0), .O_out_green(g0), .O_out_blue(b0));

  scan_doubler #(.SCANLINE_DIM(1)) u1 (
    .I_clock(clk), .I_reset(rst), .I_vid_rise(rise), .I_vid_blank(blank),
    .I_vid_hsync(hs), .I_vid_vsync(vs), .I_vid_red(r), .I_vid_green(g), .I_vid_blue(b),
    .O_out_rise(rise1), .O_out_active(act1), .O_out_hsync(hs1), .O_out_vsync(vs1),
    .O_out_pass(pass1), .O_out_red(r1), .O_out_green(g1), .O_out_blue(b1));

  int checks = 0, failures = 0, cyc = 0, pulses = 0, hs_low = 0;
  logic [23:0] cap [256];
  logic [23:0] disp [256];
  int cnt, len, n;
  bit hsp, vsl;
  logic [28:0] xp0, xp1;
  vec_t tbl [9];

  task automatic check(input string name, input logic [28:0] got, input logic [28:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // Output for a given number of clocks since the last resync: dot, pass and phase follow by division.
  function automatic logic [28:0] model_out(input int nn, input bit dim);
    int d;
    bit ps, act;
    logic [23:0] c;
    d   = (nn / 2) % HT;
    ps  = ((nn / (2 * HT)) % 2) == 1;
    act = d < len;
    c   = 24'h0;
    if (act) c = disp[d];
    if (dim && ps) c = (c >> 1) & 24'h7F7F7F;
    return {(nn % 2) == 0, act, !(d >= 275 && d <= 300), vsl, ps, c};
  endfunction

  task automatic reset_model();
    cnt = 0; len = 0; n = 0; hsp = 1; vsl = 1; xp0 = RST; xp1 = RST;
  endtask

  task automatic tick();
    logic [28:0] e0, e1;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      reset_model();
      e0 = RST; e1 = RST;
    end else begin
      e0 = xp0; e1 = xp1;
      xp0 = model_out(n, 0);
      xp1 = model_out(n, 1);
      if (rise && blank && cnt < 256) begin
        cap[cnt] = {r, g, b};
        cnt++;
      end
      if (hsp && !hs) begin
        for (int i = 0; i < 256; i++) disp[i] = cap[i];
        len = cnt; vsl = vs; cnt = 0; n = 0;
      end else n++;
      hsp = hs;
    end
    #1;
    check("out_dim0", got0, e0);
    check("out_dim1", got1, e1);
    if (rise0 && act0) pulses++;
    if (!hs0) hs_low++;
  endtask

  task automatic feed_line(input vec_t v);
    logic [23:0] px;
    pulses = 0;
    for (int d = 0; d < v.total; d++) begin
      int i;
      i = d - 30;
      px = v.kind == 0 ? {i[7:0], ~i[7:0], 8'h55} : v.kind == 1 ? 24'hFFFFFF : 24'($urandom);
      {r, g, b} = px;
      blank = i >= 0 && i < v.npix;
      hs = d >= 25;
      vs = v.vs;
      for (int c = 0; c < 4; c++) begin
        rise = c == 0;
        tick();
        if (d == 0 && c == 2) check("edge_align", {27'h0, rise0, pass0}, 29'b10);
      end
    end
    rise = 0; blank = 0;
    if (v.exp >= 0) check_int("active_pulses", pulses, v.exp);
  endtask

  initial begin
    tbl[0] = '{256, 0, 1'b1, 341, 0};
    tbl[1] = '{256, 1, 1'b0, 341, 512};
    tbl[2] = '{100, 2, 1'b1, 341, 512};
    tbl[3] = '{300, 0, 1'b1, 341, 200};
    tbl[4] = '{256, 2, 1'b1, 300, 512};
    tbl[5] = '{0,   0, 1'b1, 341, 512};
    tbl[6] = '{50,  2, 1'b1, 341, 0};
    tbl[7] = '{10,  0, 1'b1, 341, 100};
    tbl[8] = '{0,   0, 1'b1, 341, 20};
    reset_model();
    repeat (4) tick();
    check("reset_dim0", got0, RST);
    check("reset_dim1", got1, RST);
    rst = 1;
    repeat (100) tick();
    hs_low = 0; pulses = 0;
    repeat (1364) tick();
    check_int("idle_hsync_low", hs_low, 104);
    check_int("idle_active", pulses, 0);
    for (int k = 0; k < 9; k++) feed_line(tbl[k]);
    // Reset dropped in the middle of a line must clear outputs without waiting for a clock.
    hs = 1; vs = 1;
    for (int k = 0; k < 200; k++) begin
      rise = (k % 4) == 0; blank = 1; {r, g, b} = 24'($urandom);
      tick();
    end
    rise = 0; blank = 0;
    #2 rst = 0;
    #1;
    check("async_reset_dim0", got0, RST);
    check("async_reset_dim1", got1, RST);
    repeat (3) tick();
    rst = 1;
    repeat (50) tick();
    for (int k = 0; k < 9; k++) feed_line(tbl[k]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scan_doubler.md
# scan_doubler

Line-doubling scan converter placed directly downstream of the `video` block. It captures each visible 256-pixel scanline from the video pixel stream (pixel strobe every 4 `I_clock`) into one bank of a ping-pong line buffer. It replays the previously captured line twice, at double pixel rate (one pixel every 2 `I_clock`), with regenerated sync, producing 480 output lines per frame for a VGA-class encoder. An optional scanline effect halves the colour of every second replayed line.

## Interface
Parameters:
- `H_TOTAL`, 341: output dots per replayed line.
- `H_ACTIVE`, 256: buffer depth and max active dots.
- `HS_START`, 275: first output dot with hsync low.
- `HS_END`, 300: last output dot with hsync low.
- `SCANLINE_DIM`, 0: when 1, pass-1 RGB is each channel >> 1.

Ports:
- `I_clock` in 1: system clock.
- `I_reset` in 1: asynchronous, active-low reset.
- `I_vid_rise` in 1: input pixel strobe, one `I_clock` wide.
- `I_vid_blank` in 1: input visible flag; 1 means an active pixel.
- `I_vid_hsync` in 1: input hsync, active-low.
- `I_vid_vsync` in 1: input vsync, active-low.
- `I_vid_red`, `I_vid_green`, `I_vid_blue` in 8 each: input colour.
- `O_out_rise` out 1: first clock of each output pixel.
- `O_out_active` out 1: output pixel is active.
- `O_out_hsync` out 1: active-low.
- `O_out_vsync` out 1: active-low.
- `O_out_pass` out 1: 0 for the first replay of a line, 1 for the second.
- `O_out_red`, `O_out_green`, `O_out_blue` out 8 each: output colour; 0 when not active.

## Operation
- **Storage**
  - Line buffer: 2 banks × `H_ACTIVE` × 24 bit, synchronous-read RAM.
  - Write bank is `wr_bank`; read bank is `~wr_bank`.
- **Line edge:** `line_edge` = `hs_prev & ~I_vid_hsync`, where `hs_prev` is registered every `I_clock` and resets to 1.
- **Capture**
  - On a cycle with `I_vid_rise & I_vid_blank`, write RGB at `in_x` and increment `in_x`.
  - `in_x` saturates at `H_ACTIVE`; writes beyond it are dropped.
- **On `line_edge`**, all of the following update in the same clock:
  - `wr_bank` toggles.
  - `line_len <= in_x`, counting any write in the same cycle.
  - `in_x <= 0`.
  - `vs_line <= I_vid_vsync`.
  - `out_x <= 0`, `pass <= 0`, `phase <= 0`.
  - This resync takes priority over the free-running output counters at any point in an output line.
- **Output counters**
  - `phase` toggles every clock.
  - When `phase` = 1, `out_x` increments.
  - At `H_TOTAL-1`, `out_x` wraps to 0 and `pass` toggles.
  - If `line_edge` does not arrive before the next wrap, the counters keep running: pass 0, 1, 0, … replays the same bank.
- **Read:** RAM address = `out_x[7:0]`.
- **Output stage, derived from counter state:**
  - active = (`out_x` < `line_len`) and (`out_x` < `H_ACTIVE`).
  - hsync = ~(`out_x` in [`HS_START`, `HS_END`]).
  - vsync = `vs_line`.
  - RGB = buffer data when active, else 0.
  - When `SCANLINE_DIM` and `pass` = 1, each RGB channel is shifted right by 1.
- **Reset values**
  - All outputs: `O_out_rise` = 0, `O_out_active` = 0, `O_out_hsync` = 1, `O_out_vsync` = 1, `O_out_pass` = 0, RGB = 0.
  - Internal state: `line_len` = 0, `wr_bank` = 0, `vs_line` = 1, all counters 0.
- **Before the first `line_edge`:** `line_len` = 0, so output is all-inactive with valid hsync timing.
- **Reset asserted mid-line:** everything returns to the reset values; the buffer contents are don't-care because `line_len` = 0.

## Timing
- **Output alignment:** all `O_out_*` are registered, with exactly 2 `I_clock` latency from counter state (`out_x`, `phase`, `pass`) and mutually aligned.
- **`O_out_rise`:** high exactly when the delayed `phase` = 0, i.e. once per 2 clocks.
- **After a line edge:**
  - `line_edge` on clock E makes dot 0 of pass 0 appear on outputs at E+2, with `O_out_rise` = 1.
  - Dot k of pass 0 appears at E+2+2k.
  - Pass 1 dot 0 appears at E+2+2·`H_TOTAL`.
- **Steady state:** input line period = 4·341 = 1364 clocks = exactly two output lines, so resync is a no-op (counters are already at 0).
- **Line latency:** a line captured during input line N is displayed during input line N+1.
- **Write-side hazard:** none; capture and replay always use opposite banks.

## Test plan
- **Reset:** hold `I_reset` low, pulse `I_clock` -> `O_out_rise` = 0, `O_out_active` = 0, `O_out_hsync` = 1, `O_out_vsync` = 1, RGB = 0; after release with no input hsync, `O_out_hsync` is low for dots 275..300 of every output line and `O_out_active` stays 0.
- **Capture/replay:** feed 256 visible pixels with RGB = {i, ~i, 8'h55}, then an hsync fall -> from E+2, pixel k = {k, ~k, 55} on both passes; exactly 512 active `O_out_rise` pulses per input line; `O_out_pass` reads 0 then 1.
- **SCANLINE_DIM = 1:** all-white line (FFFFFF) -> pass 0 outputs FFFFFF, pass 1 outputs 7F7F7F.
- **Short line:** only 100 visible pixels -> active for dots 0..99 only; dots 100..255 are inactive with RGB = 0.
- **Early edge:** hsync fall after 300 input dots -> at E+2 the outputs show dot 0 of pass 0, with no intermediate dot emitted.
- **Vsync:** input vsync low during a line's hsync fall -> `O_out_vsync` is low for both replayed passes of that line and high for the following line.
